// File: rtl/uart_frame_pkg.sv
// Shared state encodings and size limits for the UART byte-framing controller.
package uart_frame_pkg;

   typedef enum logic {RX_IDLE, RX_COLLECT} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_WAIT} tx_state_t;

   localparam int MAX_CMD_BYTES  = 8;
   localparam int MAX_RESP_BYTES = 4;

endpackage

// File: rtl/uart_resp_serializer.sv
// Sends a RESP_BYTES response through the byte UART, first byte from the MSBs.
//   state   | meaning
//   TX_IDLE | waiting for send_resp
//   TX_LOAD | strobe trmt with the current byte
//   TX_WAIT | waiting for tx_done of that byte
module uart_resp_serializer
   import uart_frame_pkg::*;
#(
   parameter int RESP_BYTES = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    send_resp,
   input  logic [8*RESP_BYTES-1:0] resp,
   input  logic                    tx_done,
   output logic                    trmt,
   output logic [7:0]              tx_data,
   output logic                    tx_busy,
   output logic                    resp_sent
);

   localparam int BIDX_W = $clog2(RESP_BYTES) + 1;

   tx_state_t               tx_state;
   logic [BIDX_W-1:0]       bidx;
   logic [8*RESP_BYTES-1:0] resp_q;
   logic                    wait_first;

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state   <= TX_IDLE;
         bidx       <= '0;
         resp_q     <= '0;
         wait_first <= 1'b0;
         trmt       <= 1'b0;
         tx_data    <= '0;
         resp_sent  <= 1'b0;
      end else begin
         trmt      <= 1'b0;
         resp_sent <= 1'b0;
         case (tx_state)
            TX_IDLE: begin
               if (send_resp) begin
                  resp_q   <= resp;
                  bidx     <= '0;
                  tx_state <= TX_LOAD;
               end
            end
            TX_LOAD: begin
               trmt       <= 1'b1;
               tx_data    <= resp_q[8*RESP_BYTES-1 -: 8];
               resp_q     <= resp_q << 8;
               wait_first <= 1'b1;
               tx_state   <= TX_WAIT;
            end
            TX_WAIT: begin
               // tx_done is still high from the previous byte until the UART sees trmt
               if (wait_first) begin
                  wait_first <= 1'b0;
               end else if (tx_done) begin
                  if (bidx == BIDX_W'(RESP_BYTES - 1)) begin
                     resp_sent <= 1'b1;
                     tx_state  <= TX_IDLE;
                  end else begin
                     bidx     <= bidx + BIDX_W'(1);
                     tx_state <= TX_LOAD;
                  end
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   assign tx_busy = (tx_state != TX_IDLE);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frames UART bytes into MSB-first command words and serialises multi-byte responses.
//   state      | meaning
//   RX_IDLE    | no partial frame held; next byte is byte 0
//   RX_COLLECT | partial frame held; inter-byte timeout running
module uart_frame_ctrl
   import uart_frame_pkg::*;
#(
   parameter int CMD_BYTES   = 2,
   parameter int RESP_BYTES  = 1,
   parameter int TIMEOUT_CYC = 500000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rx_rdy,
   input  logic [7:0]              rx_data,
   output logic                    clr_rx_rdy,
   input  logic                    clr_cmd_rdy,
   output logic                    cmd_rdy,
   output logic [8*CMD_BYTES-1:0]  cmd,
   output logic                    ovr_err,
   output logic                    to_err,
   input  logic                    send_resp,
   input  logic [8*RESP_BYTES-1:0] resp,
   output logic                    trmt,
   output logic [7:0]              tx_data,
   input  logic                    tx_done,
   output logic                    tx_busy,
   output logic                    resp_sent
);

   localparam int CMD_W = 8 * CMD_BYTES;
   localparam int IDX_W = $clog2(CMD_BYTES) + 1;
   localparam int TO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

   rx_state_t        rx_state;
   logic [IDX_W-1:0] idx;
   logic [TO_W-1:0]  to_cnt;
   logic [CMD_W-1:0] shreg;
   logic [CMD_W-1:0] shreg_nxt;
   logic             acc;
   logic             last_byte;
   logic             timeout_hit;

   assign acc         = rx_rdy & ~clr_rx_rdy;
   assign last_byte   = (idx == IDX_W'(CMD_BYTES - 1));
   assign shreg_nxt   = (shreg << 8) | CMD_W'(rx_data);
   assign timeout_hit = (TIMEOUT_CYC != 0) && (rx_state == RX_COLLECT)
                        && (to_cnt == TO_W'(TIMEOUT_CYC));

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state   <= RX_IDLE;
         idx        <= '0;
         to_cnt     <= '0;
         shreg      <= '0;
         clr_rx_rdy <= 1'b0;
         cmd        <= '0;
         cmd_rdy    <= 1'b0;
         ovr_err    <= 1'b0;
         to_err     <= 1'b0;
      end else begin
         clr_rx_rdy <= acc;
         ovr_err    <= 1'b0;
         to_err     <= 1'b0;
         if (clr_cmd_rdy)
            cmd_rdy <= 1'b0;
         // an accepted byte takes priority over a coincident timeout
         if (acc) begin
            shreg  <= shreg_nxt;
            to_cnt <= '0;
            if (last_byte) begin
               idx      <= '0;
               rx_state <= RX_IDLE;
               if (!cmd_rdy || clr_cmd_rdy) begin
                  cmd     <= shreg_nxt;
                  cmd_rdy <= 1'b1;
               end else begin
                  ovr_err <= 1'b1;
               end
            end else begin
               idx      <= idx + IDX_W'(1);
               rx_state <= RX_COLLECT;
            end
         end else if (rx_state == RX_COLLECT) begin
            if (timeout_hit) begin
               rx_state <= RX_IDLE;
               idx      <= '0;
               to_cnt   <= '0;
               to_err   <= 1'b1;
            end else if (TIMEOUT_CYC != 0) begin
               to_cnt <= to_cnt + TO_W'(1);
            end
         end
      end
   end

   uart_resp_serializer #(
      .RESP_BYTES(RESP_BYTES)
   ) u_resp_serializer (
      .clk       (clk),
      .rst       (rst),
      .send_resp (send_resp),
      .resp      (resp),
      .tx_done   (tx_done),
      .trmt      (trmt),
      .tx_data   (tx_data),
      .tx_busy   (tx_busy),
      .resp_sent (resp_sent)
   );

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl: 3-byte commands, 2-byte responses, 20-cycle timeout.
module tb_uart_frame_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_rdy = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        clr_rx_rdy;
   logic        clr_cmd_rdy = 1'b0;
   logic        cmd_rdy;
   logic [23:0] cmd;
   logic        ovr_err;
   logic        to_err;
   logic        send_resp = 1'b0;
   logic [15:0] resp = '0;
   logic        trmt;
   logic [7:0]  tx_data;
   logic        tx_done = 1'b1;
   logic        tx_busy;
   logic        resp_sent;

   int n_tests = 0;
   int n_fail  = 0;
   int n_clr   = 0;
   int n_ovr   = 0;
   int n_to    = 0;
   int n_trmt  = 0;
   int n_sent  = 0;
   int tx_cnt  = 0;

   uart_frame_ctrl #(
      .CMD_BYTES   (3),
      .RESP_BYTES  (2),
      .TIMEOUT_CYC (20)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_rdy      (rx_rdy),
      .rx_data     (rx_data),
      .clr_rx_rdy  (clr_rx_rdy),
      .clr_cmd_rdy (clr_cmd_rdy),
      .cmd_rdy     (cmd_rdy),
      .cmd         (cmd),
      .ovr_err     (ovr_err),
      .to_err      (to_err),
      .send_resp   (send_resp),
      .resp        (resp),
      .trmt        (trmt),
      .tx_data     (tx_data),
      .tx_done     (tx_done),
      .tx_busy     (tx_busy),
      .resp_sent   (resp_sent)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (clr_rx_rdy) n_clr++;
      if (ovr_err)    n_ovr++;
      if (to_err)     n_to++;
      if (trmt)       n_trmt++;
      if (resp_sent)  n_sent++;
   end

   // UART transmitter: drops tx_done the cycle after trmt, raises it 10 cycles after trmt
   always @(negedge clk) begin
      if (trmt) begin
         tx_cnt = 10;
      end else if (tx_cnt > 0) begin
         tx_cnt--;
         if (tx_cnt == 9) tx_done = 1'b0;
         if (tx_cnt == 0) tx_done = 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic with_clr);
      logic got;
      got = 1'b0;
      @(negedge clk);
      rx_data     = b;
      rx_rdy      = 1'b1;
      clr_cmd_rdy = with_clr;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (clr_rx_rdy) got = 1'b1;
      end
      rx_rdy      = 1'b0;
      clr_cmd_rdy = 1'b0;
      chk("rx_ack", {63'd0, got}, 64'd1);
   endtask

   task automatic wait_trmt(output int n);
      n = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (trmt) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic wait_sent(output int n);
      n = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (resp_sent) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic run_resp(input logic [15:0] r, input string tag);
      int n;
      @(negedge clk);
      resp      = r;
      send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
      chk({tag, "_busy"}, {63'd0, tx_busy}, 64'd1);
      wait_trmt(n);
      chk({tag, "_trmt0_dly"}, n, 64'd1);
      chk({tag, "_byte0"}, tx_data, r[15:8]);
      // a request while busy must be ignored
      @(negedge clk);
      resp      = 16'h1234;
      send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
      wait_trmt(n);
      chk({tag, "_trmt1_dly"}, n, 64'd10);
      chk({tag, "_byte1"}, tx_data, r[7:0]);
      wait_sent(n);
      chk({tag, "_sent_dly"}, n, 64'd11);
      chk({tag, "_idle"}, {63'd0, tx_busy}, 64'd0);
   endtask

   initial begin
      int seen;
      int trmt0;
      int sent0;

      repeat (3) @(negedge clk);
      chk("rst_rx_out", {clr_rx_rdy, cmd_rdy, ovr_err, to_err}, 64'd0);
      chk("rst_cmd", cmd, 64'd0);
      chk("rst_tx_out", {trmt, tx_busy, resp_sent, tx_data}, 64'd0);
      rst = 1'b0;

      // basic 3-byte frame
      send_byte(8'hA5, 1'b0);
      send_byte(8'h12, 1'b0);
      chk("cmd_rdy_early", {63'd0, cmd_rdy}, 64'd0);
      send_byte(8'hC3, 1'b0);
      chk("cmd_rdy_1", {63'd0, cmd_rdy}, 64'd1);
      chk("cmd_1", cmd, 64'hA512C3);
      @(negedge clk);
      chk("clr_pulses", n_clr, 64'd3);

      // overrun: buffer full, frame dropped
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b0);
      chk("ovr_pulse", {63'd0, ovr_err}, 64'd1);
      chk("ovr_cmd_kept", cmd, 64'hA512C3);
      chk("ovr_cmd_rdy", {63'd0, cmd_rdy}, 64'd1);
      // release coincident with completion loads the new frame
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b1);
      chk("clr_coinc_cmd", cmd, 64'h010203);
      chk("clr_coinc_rdy", {63'd0, cmd_rdy}, 64'd1);
      chk("clr_coinc_no_ovr", {63'd0, ovr_err}, 64'd0);
      @(negedge clk);
      chk("ovr_count", n_ovr, 64'd1);
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      chk("cmd_rdy_released", {63'd0, cmd_rdy}, 64'd0);

      // inter-byte timeout resynchronises
      send_byte(8'h55, 1'b0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (to_err) seen = 1;
      end
      chk("to_early", seen, 64'd0);
      @(negedge clk);
      chk("to_err_at_21", {63'd0, to_err}, 64'd1);
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      send_byte(8'hCC, 1'b0);
      chk("resync_cmd", cmd, 64'hAABBCC);
      chk("resync_rdy", {63'd0, cmd_rdy}, 64'd1);
      @(negedge clk);
      chk("to_count", n_to, 64'd1);

      // responses; tx_done is already high (stale) at each start
      run_resp(16'hBEEF, "resp1");
      @(negedge clk);
      chk("resp1_trmt_cnt", n_trmt, 64'd2);
      chk("resp1_sent_cnt", n_sent, 64'd1);
      run_resp(16'hA1B2, "resp2");
      @(negedge clk);
      chk("resp2_trmt_cnt", n_trmt, 64'd4);

      // reset mid-frame and mid-response
      send_byte(8'h77, 1'b0);
      send_byte(8'h88, 1'b0);
      resp      = 16'h5566;
      send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
      rst       = 1'b1;
      trmt0     = n_trmt;
      sent0     = n_sent;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_cmd", cmd, 64'd0);
      chk("mid_rst_out", {clr_rx_rdy, cmd_rdy, ovr_err, to_err, trmt, tx_busy, resp_sent}, 64'd0);
      chk("mid_rst_tx_data", tx_data, 64'd0);
      repeat (30) @(negedge clk);
      chk("mid_rst_no_trmt", n_trmt - trmt0, 64'd0);
      chk("mid_rst_no_sent", n_sent - sent0, 64'd0);
      send_byte(8'h10, 1'b0);
      send_byte(8'h20, 1'b0);
      send_byte(8'h30, 1'b0);
      chk("post_rst_cmd", cmd, 64'h102030);
      chk("post_rst_rdy", {63'd0, cmd_rdy}, 64'd1);
      @(negedge clk);
      chk("err_pulses_total", {n_ovr[31:0], n_to[31:0]}, {32'd1, 32'd1});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1);
   end

endmodule
